// File: rtl/rom_sample_player_pkg.sv
// Shared definitions for the ROM sample player: state encoding, midscale level and default widths.
package rom_sample_player_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] SAMPLE_MID = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rom_sample_player_if.sv
// Control, ROM and audio signals of the sample player, grouped as one bus.
interface rom_sample_player_if
  import rom_sample_player_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              start;
  logic              pause;
  logic              stop;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              pwm_out;
  logic              playing;
  logic              done;

  modport master (
    output start, pause, stop, start_addr, end_addr, rom_data,
    input  rom_addr, sample, sample_valid, pwm_out, playing, done
  );

  modport slave (
    input  start, pause, stop, start_addr, end_addr, rom_data,
    output rom_addr, sample, sample_valid, pwm_out, playing, done
  );
endinterface

// File: rtl/rom_sample_player_pwm_dac.sv
// 1-bit PWM DAC: free-running counter compared against the level, output registered.
module rom_sample_player_pwm_dac #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_level,
  output logic              o_pwm_out
);
  logic [DATA_W-1:0] r_pwm_cnt;
  logic              r_pwm_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_pwm_out <= (r_pwm_cnt < i_level);
    end
  end

  assign o_pwm_out = r_pwm_out;
endmodule

// File: rtl/rom_sample_player.sv
// Plays a range of ROM samples at a fixed sample rate and renders them as PWM audio.
module rom_sample_player
  import rom_sample_player_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV    = 6250
) (
  input  logic                clk,
  input  logic                rst_n,
  rom_sample_player_if.slave  bus
);
  localparam int                DIV_W       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [DATA_W-1:0] SAMPLE_IDLE = DATA_W'(SAMPLE_MID);

  state_e            r_state;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] r_end_addr;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [DATA_W-1:0] r_sample;
  logic              r_sample_valid;
  logic              r_playing;
  logic              r_done;
  logic              w_start_ok;
  logic              w_tick;

  assign w_start_ok = bus.start && (bus.end_addr >= bus.start_addr);
  assign w_tick     = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_rom_addr     <= '0;
      r_end_addr     <= '0;
      r_div_cnt      <= '0;
      r_sample       <= SAMPLE_IDLE;
      r_sample_valid <= 1'b0;
      r_playing      <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      if (bus.stop) begin
        r_state   <= ST_IDLE;
        r_sample  <= SAMPLE_IDLE;
        r_div_cnt <= '0;
        r_playing <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_start_ok) begin
              r_state    <= ST_PLAY;
              r_rom_addr <= bus.start_addr;
              r_end_addr <= bus.end_addr;
              r_div_cnt  <= '0;
              r_playing  <= 1'b1;
            end
          end
          ST_PLAY, ST_PAUSE: begin
            // The pause level freezes the divider on the very cycle it is seen,
            // so playback stretches by exactly the number of paused cycles.
            if (bus.pause) begin
              r_state <= ST_PAUSE;
            end else begin
              r_state <= ST_PLAY;
              if (w_tick) begin
                r_div_cnt      <= '0;
                r_sample       <= bus.rom_data;
                r_sample_valid <= 1'b1;
                if (r_rom_addr == r_end_addr) begin
                  r_state   <= ST_DONE;
                  r_done    <= 1'b1;
                  r_playing <= 1'b0;
                end else begin
                  r_rom_addr <= r_rom_addr + 1'b1;
                end
              end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  rom_sample_player_pwm_dac #(.DATA_W(DATA_W)) u_pwm_dac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_level   (r_sample),
    .o_pwm_out (bus.pwm_out)
  );

  assign bus.rom_addr     = r_rom_addr;
  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_sample_valid;
  assign bus.playing      = r_playing;
  assign bus.done         = r_done;
endmodule

// File: tb/tb_rom_sample_player.sv
// Directed bench for rom_sample_player with DIV=4 and a small ROM image.
module tb_rom_sample_player;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rom_sample_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_sample_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] rom_lookup(input logic [ADDR_W-1:0] a);
    case (a)
      24'd0:   return 8'h55;
      24'd1:   return 8'h5C;
      24'd2:   return 8'h60;
      24'd3:   return 8'h70;
      24'd4:   return 8'h7A;
      24'd5:   return 8'h85;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.rom_data = rom_lookup(bus.rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.sample_valid && n < max);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea);
    bus.start_addr = sa;
    bus.end_addr   = ea;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    int v_seen;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.start_addr = '0; bus.end_addr = '0;

    // 1. reset values
    step(); step();
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_sample", bus.sample, 8'h80);
    check("rst_pwm", bus.pwm_out, 0);
    check("rst_playing", bus.playing, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.sample_valid, 0);
    rst_n = 1'b1;
    step();

    // 2. two-sample play 0..1
    do_start(24'd0, 24'd1);
    check("t2_playing", bus.playing, 1);
    check("t2_addr0", bus.rom_addr, 0);
    wait_valid(10, n);
    check("t2_lat1", n, 4);
    check("t2_s0", bus.sample, 8'h55);
    check("t2_addr1", bus.rom_addr, 1);
    check("t2_nodone0", bus.done, 0);
    wait_valid(10, n);
    check("t2_lat2", n, 4);
    check("t2_s1", bus.sample, 8'h5C);
    check("t2_done", bus.done, 1);
    check("t2_playing_off", bus.playing, 0);
    step();
    check("t2_done_pulse", bus.done, 0);
    check("t2_valid_pulse", bus.sample_valid, 0);
    check("t2_hold_sample", bus.sample, 8'h5C);
    check("t2_hold_addr", bus.rom_addr, 1);

    // 3. single sample from DONE, PWM duty
    do_start(24'd5, 24'd5);
    wait_valid(10, n);
    check("t3_lat", n, 4);
    check("t3_s", bus.sample, 8'h85);
    check("t3_done", bus.done, 1);
    step(); step();
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (bus.pwm_out) hi++;
      step();
    end
    check("t3_pwm_high", hi, 133);

    // 4. pause for 20 cycles after first sample
    do_start(24'd0, 24'd5);
    wait_valid(10, n);
    check("t4_lat", n, 4);
    check("t4_s0", bus.sample, 8'h55);
    bus.pause = 1'b1;
    v_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.sample_valid) v_seen++;
    end
    check("t4_no_valid_in_pause", v_seen, 0);
    check("t4_pause_addr", bus.rom_addr, 1);
    check("t4_pause_playing", bus.playing, 1);
    check("t4_pause_sample", bus.sample, 8'h55);
    bus.pause = 1'b0;
    wait_valid(10, n);
    check("t4_resume_lat", n, 4);
    check("t4_s1", bus.sample, 8'h5C);
    for (int a = 2; a <= 5; a++) begin
      wait_valid(10, n);
      check("t4_lat_n", n, 4);
      check("t4_sn", bus.sample, rom_lookup(ADDR_W'(a)));
    end
    check("t4_done", bus.done, 1);

    // 5. stop on a tick cycle, then an illegal range
    do_start(24'd0, 24'd3);
    step(); step(); step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("t5_stop_valid", bus.sample_valid, 0);
    check("t5_stop_done", bus.done, 0);
    check("t5_stop_playing", bus.playing, 0);
    check("t5_stop_sample", bus.sample, 8'h80);
    check("t5_stop_addr", bus.rom_addr, 0);
    do_start(24'd10, 24'd9);
    check("t5_bad_playing", bus.playing, 0);
    check("t5_bad_addr", bus.rom_addr, 0);
    wait_valid(8, n);
    check("t5_bad_no_valid", bus.sample_valid, 0);

    // 6. asynchronous reset mid-play
    do_start(24'd0, 24'd5);
    for (int i = 0; i < 6; i++) step();
    check("t6_pre_addr", bus.rom_addr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_addr", bus.rom_addr, 0);
    check("t6_rst_sample", bus.sample, 8'h80);
    check("t6_rst_playing", bus.playing, 0);
    check("t6_rst_done", bus.done, 0);
    check("t6_rst_valid", bus.sample_valid, 0);
    check("t6_rst_pwm", bus.pwm_out, 0);
    step();
    rst_n = 1'b1;
    v_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done || bus.sample_valid) v_seen++;
    end
    check("t6_quiet_after_rst", v_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
